// File: rtl/dmem_lsu.sv
// Purpose: memory-stage load/store unit, initiator on the data-memory req/gnt/rvalid bus.
// Latency: fastest access (gnt in issue cycle, rvalid next) stalls 2 cycles; load data registered, valid in DONE.
// Backpressure: holds req with frozen fields until gnt; stalls the pipeline until rvalid or timeout.
//
// Ports: clk_i/rst_i (sync, active-high); mem_* request from the M stage; dmem_* data-memory bus;
//        load_data_o/load_valid_o load result; dmem_stall_o to hazard unit; misaligned_o/bus_err_o to trap logic.
module dmem_lsu #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_valid_i,
    input  logic              mem_squash_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              dmem_stall_o,
    output logic              misaligned_o,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    // Timeout fires on the cycle the wait counter would reach MAX_WAIT.
    localparam bit          TO_EN    = (MAX_WAIT != 0);
    localparam logic [15:0] TO_LIMIT = TO_EN ? 16'(MAX_WAIT - 1) : 16'd0;

    state_e             state_q, state_d;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        load_data_q, load_data_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               in_idle;
    logic               access_ok;
    logic               misaligned;
    logic               start;
    logic               capture;
    logic               timeout;
    logic               req;

    // Request fields: live M-stage inputs in the issue cycle, registered copies afterwards.
    logic               f_we;
    logic [1:0]         f_size;
    logic [ADDR_W-1:0]  f_addr;
    logic [31:0]        f_wdata;
    logic [1:0]         lane;
    logic [3:0]         be_calc;
    logic [31:0]        wdata_calc;

    logic [31:0]        rshift;
    logic [31:0]        load_ext;

    assign in_idle    = (state_q == S_IDLE);
    assign misaligned = ((mem_size_i == 2'd1) && mem_addr_i[0]) ||
                        (mem_size_i[1] && (mem_addr_i[1:0] != 2'b00));
    assign access_ok  = mem_valid_i && !mem_squash_i && !rst_i && in_idle;
    assign start      = access_ok && !misaligned;
    assign misaligned_o = access_ok && misaligned;

    assign f_we    = in_idle ? mem_we_i    : we_q;
    assign f_size  = in_idle ? mem_size_i  : size_q;
    assign f_addr  = in_idle ? mem_addr_i  : addr_q;
    assign f_wdata = in_idle ? mem_wdata_i : wdata_q;
    assign lane    = f_addr[1:0];

    always_comb begin
        be_calc = 4'b1111;
        case (f_size)
            2'd0:    be_calc = 4'b0001 << lane;
            2'd1:    be_calc = 4'b0011 << {lane[1], 1'b0};
            default: be_calc = 4'b1111;
        endcase
    end

    assign wdata_calc = f_wdata << {lane, 3'b000};

    // Load extraction always uses the registered access: rvalid only arrives in WAIT.
    assign rshift = dmem_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rshift;
        case (size_q)
            2'd0:    load_ext = {{24{!uns_q && rshift[7]}},  rshift[7:0]};
            2'd1:    load_ext = {{16{!uns_q && rshift[15]}}, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    assign timeout = TO_EN && (cnt_q == TO_LIMIT);

    always_comb begin
        state_d      = state_q;
        req          = 1'b0;
        dmem_stall_o = 1'b0;
        capture      = 1'b0;
        cnt_d        = 16'd0;
        err_d        = 1'b0;
        load_data_d  = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    req          = 1'b1;
                    dmem_stall_o = 1'b1;
                    capture      = 1'b1;
                    state_d      = dmem_gnt_i ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                req          = 1'b1;
                dmem_stall_o = 1'b1;
                if (dmem_gnt_i) begin
                    state_d = S_WAIT;
                end else if (timeout) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                dmem_stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    load_data_d = load_ext;
                    state_d     = S_DONE;
                end else if (timeout) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                // The M stage advances on this edge; never reissue the same instruction.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            if (capture) begin
                we_q    <= mem_we_i;
                size_q  <= mem_size_i;
                uns_q   <= mem_unsigned_i;
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
            end
        end
    end

    // Bus fields are zeroed whenever no request is presented.
    assign dmem_req_o   = req;
    assign dmem_we_o    = req && f_we;
    assign dmem_be_o    = req ? be_calc : 4'b0000;
    assign dmem_addr_o  = req ? {f_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata_o = req ? wdata_calc : 32'd0;

    assign load_data_o  = load_data_q;
    assign load_valid_o = (state_q == S_DONE) && !we_q && !err_q;
    assign bus_err_o    = err_q;

endmodule
